// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin owner arbitration for the per-core cache bus masters, plus a
// single-outstanding bridge that carries each granted line transfer onto the
// memory slave port. The owner keeps the bus for as long as its request stays
// high, so a flush-victim write and the refill read that follows it can run
// back to back without another master getting in between.
module bus_arbiter #(
    parameter  int NUM_MASTERS = 4,
    parameter  int ADDR_W      = 32,
    parameter  int LINE_BYTES  = 4,
    parameter  int MAX_HOLD    = 4,
    localparam int DW          = 8 * LINE_BYTES,
    localparam int OW          = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_hreq,
    input  logic [NUM_MASTERS-1:0]        m_htrans,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
    input  logic [NUM_MASTERS-1:0]        m_hwrite,
    input  logic [NUM_MASTERS*DW-1:0]     m_hwdata,
    output logic [NUM_MASTERS-1:0]        m_hgrant,
    output logic [NUM_MASTERS-1:0]        m_hready,
    output logic [DW-1:0]                 m_hrdata,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_write,
    output logic [DW-1:0]                 mem_wdata,
    input  logic                          mem_ready,
    input  logic [DW-1:0]                 mem_rdata,
    output logic [OW-1:0]                 bus_owner
);

    // The hold counter only has to reach MAX_HOLD; keep at least one bit so
    // the "never force" setting (MAX_HOLD = 0) still elaborates cleanly.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        DPH,
        WMEM
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [NUM_MASTERS-1:0]   w_grantNext;
    logic [NUM_MASTERS-1:0]   r_ready;
    logic [NUM_MASTERS-1:0]   w_readyNext;
    logic [DW-1:0]            r_rdata;
    logic [DW-1:0]            w_rdataNext;
    logic                     r_memReq;
    logic                     w_memReqNext;
    logic [ADDR_W-1:0]        r_memAddr;
    logic [ADDR_W-1:0]        w_memAddrNext;
    logic                     r_memWrite;
    logic                     w_memWriteNext;
    logic [DW-1:0]            r_memWdata;
    logic [DW-1:0]            w_memWdataNext;
    logic [OW-1:0]            r_owner;
    logic [OW-1:0]            w_ownerNext;
    logic [OW-1:0]            r_lastOwner;
    logic [OW-1:0]            w_lastOwnerNext;
    logic [HW-1:0]            r_holdCnt;
    logic [HW-1:0]            w_holdCntNext;
    logic [ADDR_W-1:0]        r_addrLatch;
    logic [ADDR_W-1:0]        w_addrLatchNext;
    logic                     r_writeLatch;
    logic                     w_writeLatchNext;

    logic                     w_ownHtrans;
    logic                     w_ownHreq;
    logic                     w_ownHwrite;
    logic [ADDR_W-1:0]        w_ownHaddr;
    logic [DW-1:0]            w_ownHwdata;
    logic [NUM_MASTERS-1:0]   w_ownerOnehot;
    logic [OW-1:0]            w_pick;
    logic [NUM_MASTERS-1:0]   w_pickOnehot;
    logic                     w_pickValid;
    logic                     w_othersReq;
    logic                     w_holdDone;
    logic                     w_forceRelease;
    logic [HW-1:0]            w_holdCntInc;

    // Select the current owner's request, strobe, address, direction and
    // write data out of the flattened per-master buses. Strobes from every
    // other master are simply not looked at.
    always_comb begin
        w_ownHtrans   = 1'b0;
        w_ownHreq     = 1'b0;
        w_ownHwrite   = 1'b0;
        w_ownHaddr    = '0;
        w_ownHwdata   = '0;
        w_ownerOnehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_owner == OW'(i)) begin
                w_ownHtrans      = m_htrans[i];
                w_ownHreq        = m_hreq[i];
                w_ownHwrite      = m_hwrite[i];
                w_ownHaddr       = m_haddr[i*ADDR_W +: ADDR_W];
                w_ownHwdata      = m_hwdata[i*DW +: DW];
                w_ownerOnehot[i] = 1'b1;
            end
        end
    end

    // Round-robin pick: scan forward from the master after the previous
    // owner, wrapping around, and take the first one with its request up.
    // The previous owner itself is visited last, so it cannot starve others.
    always_comb begin
        w_pick       = '0;
        w_pickOnehot = '0;
        w_pickValid  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!w_pickValid && m_hreq[(int'(r_lastOwner) + k) % NUM_MASTERS]) begin
                w_pickValid = 1'b1;
                w_pick      = OW'((int'(r_lastOwner) + k) % NUM_MASTERS);
                w_pickOnehot[(int'(r_lastOwner) + k) % NUM_MASTERS] = 1'b1;
            end
        end
    end

    // Forced-release decision for the transfer completing this cycle. The
    // count saturates, and the test is "at or beyond the limit", so a master
    // that already used up its allowance while nobody else was waiting is
    // released at the first completion after a competitor shows up.
    always_comb begin
        w_othersReq    = |(m_hreq & ~w_ownerOnehot);
        w_holdDone     = (MAX_HOLD != 0) && ((int'(r_holdCnt) + 1) >= MAX_HOLD);
        w_forceRelease = w_holdDone && w_othersReq;
        if (int'(r_holdCnt) < MAX_HOLD) begin
            w_holdCntInc = r_holdCnt + HW'(1);
        end else begin
            w_holdCntInc = r_holdCnt;
        end
    end

    // Next-state and next-output logic. Every output is a register, so this
    // block computes what each register takes at the coming edge; anything
    // a state does not mention keeps its current value.
    always_comb begin
        w_stateNext      = r_state;
        w_grantNext      = r_grant;
        w_readyNext      = r_ready;
        w_rdataNext      = r_rdata;
        w_memReqNext     = r_memReq;
        w_memAddrNext    = r_memAddr;
        w_memWriteNext   = r_memWrite;
        w_memWdataNext   = r_memWdata;
        w_ownerNext      = r_owner;
        w_lastOwnerNext  = r_lastOwner;
        w_holdCntNext    = r_holdCnt;
        w_addrLatchNext  = r_addrLatch;
        w_writeLatchNext = r_writeLatch;

        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_grantNext   = w_pickOnehot;
                    w_readyNext   = w_pickOnehot;
                    w_ownerNext   = w_pick;
                    w_holdCntNext = '0;
                    w_stateNext   = OWNED;
                end
            end

            OWNED: begin
                // A start strobe wins over a dropped request in the same
                // cycle: the transfer is carried out and the release is
                // taken on the next pass through this state.
                if (w_ownHtrans) begin
                    w_addrLatchNext  = w_ownHaddr;
                    w_writeLatchNext = w_ownHwrite;
                    w_readyNext      = '0;
                    w_stateNext      = DPH;
                end else if (!w_ownHreq) begin
                    w_grantNext     = '0;
                    w_readyNext     = '0;
                    w_lastOwnerNext = r_owner;
                    w_stateNext     = IDLE;
                end
            end

            DPH: begin
                // Write data trails the address by a cycle, so it is picked
                // up here rather than alongside the address.
                w_memReqNext   = 1'b1;
                w_memAddrNext  = r_addrLatch;
                w_memWriteNext = r_writeLatch;
                w_memWdataNext = w_ownHwdata;
                w_stateNext    = WMEM;
            end

            WMEM: begin
                if (mem_ready) begin
                    w_memReqNext  = 1'b0;
                    w_holdCntNext = w_holdCntInc;
                    if (!r_memWrite) begin
                        w_rdataNext = mem_rdata;
                    end
                    if (w_forceRelease) begin
                        w_grantNext     = '0;
                        w_readyNext     = '0;
                        w_lastOwnerNext = r_owner;
                        w_stateNext     = IDLE;
                    end else begin
                        w_readyNext = w_ownerOnehot;
                        w_stateNext = OWNED;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State and output registers. Reset is synchronous; it drops any memory
    // request in flight, and because the machine comes back in IDLE a late
    // mem_ready from the abandoned request is never looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_ready      <= '0;
            r_rdata      <= '0;
            r_memReq     <= 1'b0;
            r_memAddr    <= '0;
            r_memWrite   <= 1'b0;
            r_memWdata   <= '0;
            r_owner      <= '0;
            r_lastOwner  <= OW'(NUM_MASTERS - 1);
            r_holdCnt    <= '0;
            r_addrLatch  <= '0;
            r_writeLatch <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_grant      <= w_grantNext;
            r_ready      <= w_readyNext;
            r_rdata      <= w_rdataNext;
            r_memReq     <= w_memReqNext;
            r_memAddr    <= w_memAddrNext;
            r_memWrite   <= w_memWriteNext;
            r_memWdata   <= w_memWdataNext;
            r_owner      <= w_ownerNext;
            r_lastOwner  <= w_lastOwnerNext;
            r_holdCnt    <= w_holdCntNext;
            r_addrLatch  <= w_addrLatchNext;
            r_writeLatch <= w_writeLatchNext;
        end
    end

    assign m_hgrant  = r_grant;
    assign m_hready  = r_ready;
    assign m_hrdata  = r_rdata;
    assign mem_req   = r_memReq;
    assign mem_addr  = r_memAddr;
    assign mem_write = r_memWrite;
    assign mem_wdata = r_memWdata;
    assign bus_owner = r_owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed scenarios followed by randomized ownership rounds. The bench plays
// every cache master and the memory slave; expectations come from a
// transaction-level model (round-robin pick, completions per grant, memory
// contents and the last read line).
module tb_bus_arbiter;

    localparam int NM       = 4;
    localparam int AW       = 32;
    localparam int DWT      = 32;
    localparam int MAX_HOLD = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM-1:0]   m_hreq;
    logic [NM-1:0]   m_htrans;
    logic [NM*AW-1:0]  m_haddr;
    logic [NM-1:0]   m_hwrite;
    logic [NM*DWT-1:0] m_hwdata;
    logic [NM-1:0]   m_hgrant;
    logic [NM-1:0]   m_hready;
    logic [DWT-1:0]  m_hrdata;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_write;
    logic [DWT-1:0]  mem_wdata;
    logic            mem_ready;
    logic [DWT-1:0]  mem_rdata;
    logic [1:0]      bus_owner;

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    int              lastOwner;
    int              completions;
    logic [31:0]     expHrdata;
    logic [31:0]     memModel [logic [31:0]];

    bus_arbiter #(
        .NUM_MASTERS(NM),
        .ADDR_W     (AW),
        .LINE_BYTES (4),
        .MAX_HOLD   (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_hreq    (m_hreq),
        .m_htrans  (m_htrans),
        .m_haddr   (m_haddr),
        .m_hwrite  (m_hwrite),
        .m_hwdata  (m_hwdata),
        .m_hgrant  (m_hgrant),
        .m_hready  (m_hready),
        .m_hrdata  (m_hrdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_owner (bus_owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: inputs set before this are sampled at the edge, outputs are
    // read 1 time unit afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester scanning forward from the master after the last owner.
    function automatic int rrPick(input int last, input logic [3:0] req);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".grant"},    m_hgrant,  0);
        checkOutput({tag, ".ready"},    m_hready,  0);
        checkOutput({tag, ".hrdata"},   m_hrdata,  0);
        checkOutput({tag, ".memReq"},   mem_req,   0);
        checkOutput({tag, ".memAddr"},  mem_addr,  0);
        checkOutput({tag, ".memWrite"}, mem_write, 0);
        checkOutput({tag, ".memWdata"}, mem_wdata, 0);
        checkOutput({tag, ".owner"},    bus_owner, 0);
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        m_hreq    = '0;
        m_htrans  = '0;
        m_haddr   = '0;
        m_hwrite  = '0;
        m_hwdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        rst       = 1'b0;
        lastOwner = NM - 1;
        expHrdata = '0;
    endtask

    // From IDLE with m_hreq already driven: one edge later the model's pick
    // must hold grant, ready and bus_owner.
    task automatic applyStimulus(input string tag, output int owner);
        tick();
        owner = rrPick(lastOwner, m_hreq);
        completions = 0;
        checkOutput({tag, ".grant"}, m_hgrant, 64'd1 << owner);
        checkOutput({tag, ".ready"}, m_hready, 64'd1 << owner);
        checkOutput({tag, ".owner"}, bus_owner, owner);
    endtask

    // One full line transfer by master m, which must own the bus in OWNED.
    task automatic doTransfer(input int m, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input int lat,
                              input logic dropReq, output bit released);
        logic [31:0] rdata;
        m_htrans[m]            = 1'b1;
        m_haddr[m*AW +: AW]    = addr;
        m_hwrite[m]            = wr;
        if (dropReq) m_hreq[m] = 1'b0;
        tick();
        m_htrans[m]            = 1'b0;
        m_haddr[m*AW +: AW]    = $urandom;
        m_hwdata[m*DWT +: DWT] = wdata;
        checkOutput("dph.ready",  m_hready, 0);
        checkOutput("dph.memReq", mem_req,  0);
        tick();
        m_hwdata[m*DWT +: DWT] = ~wdata;
        checkOutput("mem.req",   mem_req,   1);
        checkOutput("mem.addr",  mem_addr,  addr);
        checkOutput("mem.write", mem_write, wr);
        if (wr) checkOutput("mem.wdata", mem_wdata, wdata);
        for (int c = 1; c < lat; c++) begin
            tick();
            checkOutput("wait.req",   mem_req,  1);
            checkOutput("wait.addr",  mem_addr, addr);
            checkOutput("wait.ready", m_hready, 0);
        end
        rdata     = memModel.exists(addr) ? memModel[addr] : $urandom;
        mem_ready = 1'b1;
        mem_rdata = wr ? $urandom : rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (wr) memModel[addr] = wdata;
        else    expHrdata      = rdata;
        completions++;
        released = (completions >= MAX_HOLD) && ((m_hreq & ~(4'b1 << m)) != 0);
        checkOutput("done.memReq", mem_req,  0);
        checkOutput("done.hrdata", m_hrdata, expHrdata);
        if (released) begin
            checkOutput("done.grantReleased", m_hgrant, 0);
            checkOutput("done.readyReleased", m_hready, 0);
            lastOwner = m;
        end else begin
            checkOutput("done.grantHeld", m_hgrant, 64'd1 << m);
            checkOutput("done.readyHeld", m_hready, 64'd1 << m);
        end
    endtask

    // Owner m has dropped its request: next edge returns to IDLE.
    task automatic releaseOwner(input string tag, input int m);
        m_hreq[m] = 1'b0;
        tick();
        checkOutput({tag, ".grant"}, m_hgrant, 0);
        checkOutput({tag, ".ready"}, m_hready, 0);
        lastOwner = m;
    endtask

    initial begin
        int   own;
        bit   rel;
        logic [3:0] mask;
        int   k;

        // Reset values
        applyReset();
        checkAllZero("reset");

        // Single read by master 1
        memModel[32'h40] = 32'hDEADBEEF;
        m_hreq[1] = 1'b1;
        applyStimulus("read.grant", own);
        checkOutput("read.grant0010", m_hgrant, 4'b0010);
        doTransfer(1, 32'h40, 1'b0, 32'h0, 3, 1'b0, rel);
        checkOutput("read.rdata", m_hrdata, 32'hDEADBEEF);
        releaseOwner("read.release", 1);

        // Flush then refill (plus one more) under a single grant
        m_hreq[0] = 1'b1;
        applyStimulus("flush.grant", own);
        doTransfer(0, 32'h100, 1'b1, 32'h11223344, 1, 1'b0, rel);
        doTransfer(0, 32'h200, 1'b0, 32'h0, 2, 1'b0, rel);
        doTransfer(0, 32'h100, 1'b0, 32'h0, 1, 1'b0, rel);
        checkOutput("flush.refillData", m_hrdata, 32'h11223344);
        releaseOwner("flush.release", 0);

        // Round robin from reset: order 0,1,2,3
        applyReset();
        m_hreq = 4'b1111;
        for (int n = 0; n < NM; n++) begin
            applyStimulus("rr.grant", own);
            checkOutput("rr.order", bus_owner, n);
            doTransfer(own, 32'h300 + 32'(n * 16), 1'($urandom_range(0, 1)), $urandom, 1, 1'b0, rel);
            releaseOwner("rr.release", own);
        end
        m_hreq = 4'b0101;
        applyStimulus("rr.wrapTo0", own);
        checkOutput("rr.wrapOwner", bus_owner, 0);
        doTransfer(0, 32'h340, 1'b0, 32'h0, 1, 1'b0, rel);
        releaseOwner("rr.release0", 0);
        applyStimulus("rr.then2", own);
        checkOutput("rr.owner2", bus_owner, 2);
        releaseOwner("rr.release2", 2);

        // Forced release after MAX_HOLD completions with master 3 waiting
        m_hreq = 4'b0001;
        applyStimulus("force.grant0", own);
        m_hreq[3] = 1'b1;
        doTransfer(0, 32'h400, 1'b0, 32'h0, 1, 1'b0, rel);
        checkOutput("force.notYet", rel, 0);
        doTransfer(0, 32'h410, 1'b1, $urandom, 2, 1'b0, rel);
        checkOutput("force.released", m_hgrant, 0);
        applyStimulus("force.grant3", own);
        checkOutput("force.owner3", m_hgrant, 4'b1000);
        m_hreq[0] = 1'b0;
        releaseOwner("force.release3", 3);

        // Start strobe and request drop in the same cycle
        m_hreq = 4'b0001;
        applyStimulus("drop.grant", own);
        doTransfer(0, 32'h500, 1'b1, 32'hA5A5_5A5A, 2, 1'b1, rel);
        tick();
        checkOutput("drop.releaseGrant", m_hgrant, 0);
        checkOutput("drop.releaseReady", m_hready, 0);
        lastOwner = 0;

        // Reset while waiting on memory, then a late mem_ready
        m_hreq = 4'b0010;
        applyStimulus("rstmid.grant", own);
        m_htrans[1]          = 1'b1;
        m_haddr[1*AW +: AW]  = 32'h80;
        m_hwrite[1]          = 1'b0;
        tick();
        m_htrans[1] = 1'b0;
        tick();
        checkOutput("rstmid.memReq", mem_req, 1);
        rst    = 1'b1;
        m_hreq = '0;
        tick();
        rst = 1'b0;
        checkAllZero("rstmid");
        lastOwner = NM - 1;
        expHrdata = '0;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        checkOutput("late.ready",  m_hready, 0);
        checkOutput("late.hrdata", m_hrdata, 0);
        checkOutput("late.grant",  m_hgrant, 0);
        checkOutput("late.memReq", mem_req,  0);

        // Randomized ownership rounds
        for (int r = 0; r < 30; r++) begin
            mask   = 4'($urandom_range(1, 15));
            m_hreq = mask;
            applyStimulus("rand.grant", own);
            k   = $urandom_range(1, 3);
            rel = 1'b0;
            for (int j = 0; j < k && !rel; j++) begin
                doTransfer(own, 32'h1000 + 32'($urandom_range(0, 7) * 16),
                           1'($urandom_range(0, 1)), $urandom,
                           $urandom_range(1, 4), 1'b0, rel);
            end
            if (rel) begin
                m_hreq = '0;
            end else begin
                m_hreq = '0;
                releaseOwner("rand.release", own);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
